// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the MM:SS clock time-set path.
//   state_t     - time-set FSM states
//   TENS_MAX    - highest legal tens digit (5)
//   UNITS_MAX   - highest legal units digit (9)
//   DIG_*       - digit index, also the bit position in digit_blank
//   bcd_inc     - wrapping BCD increment; out-of-range values restart at 0
//   edit_digit  - digit index edited in a given EDIT state
package clock_pkg;

    typedef enum logic [2:0] {IDLE, EDIT_MT, EDIT_MU, EDIT_ST, EDIT_SU, COMMIT} state_t;

    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

    localparam logic [1:0] DIG_MT = 2'd3;
    localparam logic [1:0] DIG_MU = 2'd2;
    localparam logic [1:0] DIG_ST = 2'd1;
    localparam logic [1:0] DIG_SU = 2'd0;

    function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [1:0] edit_digit(input state_t s);
        case (s)
            EDIT_MT: return DIG_MT;
            EDIT_MU: return DIG_MU;
            EDIT_ST: return DIG_ST;
            default: return DIG_SU;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces one active-low pushbutton and
// emits a one-cycle pulse on each accepted press (release makes no pulse).
//   clk, rst_n - clock, async active-low reset
//   btn_n_i    - raw active-low button, asynchronous to clk
//   press_o    - registered one-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q, deb_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, flip;

    assign differ  = sync2_q != deb_q;
    // The counter holds the number of differing samples already seen, so the
    // DEBOUNCE_CYCLES-th differing sample is the one that flips the level.
    assign flip    = differ && cnt_q == CNT_LAST;
    assign cnt_d   = (differ && !flip) ? cnt_q + CW'(1) : '0;
    assign press_o = press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= flip ? sync2_q : deb_q;
            press_q <= flip && !sync2_q;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: pushbutton time-set controller for the MM:SS clock.
//   clk, rst_n           - clock, async active-low reset
//   btn_mode_n/inc_n     - raw active-low mode / increment buttons
//   cur_*                - live BCD time from the counter
//   set_*                - edited BCD time (shadow registers)
//   load                 - one-cycle strobe, counter loads set_*
//   editing              - high in any EDIT state
//   digit_blank          - blink blank request, bit = DIG_* index
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_sec_units,
    output logic [3:0] set_min_tens,
    output logic [3:0] set_min_units,
    output logic [3:0] set_sec_tens,
    output logic [3:0] set_sec_units,
    output logic       load,
    output logic       editing,
    output logic [3:0] digit_blank
);

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic              mode_ev, inc_ev, bump, restart, wrap;
    logic [1:0]        sel;
    state_t            state_q, state_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst_n(rst_n), .btn_n_i(btn_mode_n), .press_o(mode_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst_n(rst_n), .btn_n_i(btn_inc_n), .press_o(inc_ev)
    );

    assign sel     = edit_digit(state_q);
    assign editing = state_q inside {EDIT_MT, EDIT_MU, EDIT_ST, EDIT_SU};
    assign load    = state_q == COMMIT;

    assign set_min_tens  = dig_q[DIG_MT];
    assign set_min_units = dig_q[DIG_MU];
    assign set_sec_tens  = dig_q[DIG_ST];
    assign set_sec_units = dig_q[DIG_SU];

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        bump    = 1'b0;
        case (state_q)
            IDLE: if (mode_ev) begin
                dig_d   = {cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units};
                state_d = EDIT_MT;
            end
            EDIT_MT: state_d = mode_ev ? EDIT_MU : state_q;
            EDIT_MU: state_d = mode_ev ? EDIT_ST : state_q;
            EDIT_ST: state_d = mode_ev ? EDIT_SU : state_q;
            EDIT_SU: state_d = mode_ev ? COMMIT : state_q;
            default: state_d = IDLE;
        endcase
        // A simultaneous mode event takes priority and swallows the increment.
        if (editing && inc_ev && !mode_ev) begin
            dig_d[sel] = bcd_inc(dig_q[sel], (sel == DIG_MT || sel == DIG_ST) ? TENS_MAX : UNITS_MAX);
            bump       = 1'b1;
        end
    end

    // Restarting the blink on any change keeps the edited digit visible at once.
    assign restart       = bump || state_d != state_q;
    assign wrap          = blink_cnt_q == BLINK_LAST;
    assign blink_cnt_d   = (restart || wrap) ? '0 : blink_cnt_q + BW'(1);
    assign blink_phase_d = !restart && (blink_phase_q ^ wrap);

    assign digit_blank = (editing && blink_phase_q) ? 4'b0001 << sel : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dig_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dig_q         <= dig_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_inc_n = 1'b1;
    logic [3:0] cur_min_tens = 4'd0, cur_min_units = 4'd0, cur_sec_tens = 4'd0, cur_sec_units = 4'd0;
    logic [3:0] set_min_tens, set_min_units, set_sec_tens, set_sec_units;
    logic       load, editing;
    logic [3:0] digit_blank;

    int asserts = 0;
    int fails = 0;
    int load_cnt = 0;
    logic [15:0] load_set = 16'h0;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
        .cur_min_tens(cur_min_tens), .cur_min_units(cur_min_units),
        .cur_sec_tens(cur_sec_tens), .cur_sec_units(cur_sec_units),
        .set_min_tens(set_min_tens), .set_min_units(set_min_units),
        .set_sec_tens(set_sec_tens), .set_sec_units(set_sec_units),
        .load(load), .editing(editing), .digit_blank(digit_blank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            load_set = {set_min_tens, set_min_units, set_sec_tens, set_sec_units};
        end
    end

    function automatic logic [15:0] set_all();
        return {set_min_tens, set_min_units, set_sec_tens, set_sec_units};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units} = v;
    endtask

    task automatic press(input bit m, input bit i, input int low);
        @(negedge clk);
        if (m) btn_mode_n = 1'b0;
        if (i) btn_inc_n = 1'b0;
        repeat (low) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_inc_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        asserts++; if (set_all() !== 16'h0) begin fails++; $display("FAIL reset_set got=%h exp=0000", set_all()); end
        asserts++; if (load !== 1'b0) begin fails++; $display("FAIL reset_load got=%b exp=0", load); end
        asserts++; if (editing !== 1'b0) begin fails++; $display("FAIL reset_editing got=%b exp=0", editing); end
        asserts++; if (digit_blank !== 4'b0) begin fails++; $display("FAIL reset_blank got=%b exp=0000", digit_blank); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode_capture();
        set_cur(16'h5857);
        @(negedge clk);
        btn_mode_n = 1'b0;
        repeat (6) @(negedge clk);
        asserts++; if (dut.u_mode.press_o !== 1'b1) begin fails++; $display("FAIL mode_event_edge6 got=%b exp=1", dut.u_mode.press_o); end
        asserts++; if (editing !== 1'b0) begin fails++; $display("FAIL mode_not_yet got=%b exp=0", editing); end
        @(negedge clk);
        asserts++; if (editing !== 1'b1) begin fails++; $display("FAIL mode_editing got=%b exp=1", editing); end
        asserts++; if (dut.state_q !== EDIT_MT) begin fails++; $display("FAIL mode_state got=%0d exp=%0d", dut.state_q, EDIT_MT); end
        asserts++; if (set_all() !== 16'h5857) begin fails++; $display("FAIL mode_capture got=%h exp=5857", set_all()); end
        btn_mode_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_edit_sequence();
        int l0;
        press(0, 1, 6);
        asserts++; if (set_min_tens !== 4'd0) begin fails++; $display("FAIL mt_wrap got=%0d exp=0", set_min_tens); end
        press(1, 0, 6);
        press(0, 1, 6);
        asserts++; if (set_min_units !== 4'd9) begin fails++; $display("FAIL mu_inc got=%0d exp=9", set_min_units); end
        press(0, 1, 6);
        asserts++; if (set_min_units !== 4'd0) begin fails++; $display("FAIL mu_wrap got=%0d exp=0", set_min_units); end
        press(1, 0, 6);
        press(1, 0, 6);
        press(0, 1, 6);
        asserts++; if (set_sec_units !== 4'd8) begin fails++; $display("FAIL su_inc1 got=%0d exp=8", set_sec_units); end
        press(0, 1, 6);
        asserts++; if (set_sec_units !== 4'd9) begin fails++; $display("FAIL su_inc2 got=%0d exp=9", set_sec_units); end
        press(0, 1, 6);
        asserts++; if (set_sec_units !== 4'd0) begin fails++; $display("FAIL su_wrap got=%0d exp=0", set_sec_units); end
        l0 = load_cnt;
        press(1, 0, 6);
        asserts++; if (load_cnt - l0 !== 1) begin fails++; $display("FAIL commit_load_cycles got=%0d exp=1", load_cnt - l0); end
        asserts++; if (load_set !== 16'h0050) begin fails++; $display("FAIL commit_value got=%h exp=0050", load_set); end
        asserts++; if (editing !== 1'b0) begin fails++; $display("FAIL commit_idle got=%b exp=0", editing); end
        asserts++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL commit_state got=%0d exp=%0d", dut.state_q, IDLE); end
    endtask

    task automatic test_glitch();
        press(1, 0, 6);
        press(1, 0, 6);
        press(1, 0, 6);
        asserts++; if (dut.state_q !== EDIT_ST) begin fails++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, EDIT_ST); end
        press(0, 1, 3);
        asserts++; if (set_sec_tens !== 4'd5) begin fails++; $display("FAIL glitch_ignored got=%0d exp=5", set_sec_tens); end
        press(0, 1, 4);
        asserts++; if (set_sec_tens !== 4'd0) begin fails++; $display("FAIL stable4_inc got=%0d exp=0", set_sec_tens); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        set_cur(16'h5857);
        press(1, 0, 6);
        press(1, 0, 6);
        press(1, 1, 6);
        asserts++; if (dut.state_q !== EDIT_ST) begin fails++; $display("FAIL both_state got=%0d exp=%0d", dut.state_q, EDIT_ST); end
        asserts++; if (set_min_units !== 4'd8) begin fails++; $display("FAIL both_mu_kept got=%0d exp=8", set_min_units); end
    endtask

    task automatic test_blink();
        logic [3:0] exp_blank;
        @(negedge clk);
        btn_inc_n = 1'b0;
        repeat (6) @(negedge clk);
        btn_inc_n = 1'b1;
        @(negedge clk);
        asserts++; if (set_sec_tens !== 4'd0) begin fails++; $display("FAIL blink_inc got=%0d exp=0", set_sec_tens); end
        for (int j = 0; j < 24; j++) begin
            exp_blank = ((j / 8) % 2 == 1) ? 4'b0010 : 4'b0000;
            asserts++; if (digit_blank !== exp_blank) begin fails++; $display("FAIL blink_cycle%0d got=%b exp=%b", j, digit_blank, exp_blank); end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        set_cur(16'h9C7F);
        press(1, 0, 6);
        asserts++; if (set_all() !== 16'h9C7F) begin fails++; $display("FAIL oor_capture got=%h exp=9c7f", set_all()); end
        press(0, 1, 6);
        asserts++; if (set_min_tens !== 4'd0) begin fails++; $display("FAIL oor_tens got=%0d exp=0", set_min_tens); end
        press(1, 0, 6);
        press(0, 1, 6);
        asserts++; if (set_min_units !== 4'd0) begin fails++; $display("FAIL oor_units got=%0d exp=0", set_min_units); end
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        apply_reset();
        set_cur(16'h5857);
        l0 = load_cnt;
        press(1, 0, 6);
        press(1, 0, 6);
        asserts++; if (dut.state_q !== EDIT_MU) begin fails++; $display("FAIL mid_state got=%0d exp=%0d", dut.state_q, EDIT_MU); end
        rst_n = 1'b0;
        @(negedge clk);
        asserts++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL mid_reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
        asserts++; if (set_all() !== 16'h0) begin fails++; $display("FAIL mid_reset_set got=%h exp=0000", set_all()); end
        asserts++; if (editing !== 1'b0) begin fails++; $display("FAIL mid_reset_editing got=%b exp=0", editing); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        asserts++; if (load_cnt !== l0) begin fails++; $display("FAIL mid_reset_no_load got=%0d exp=%0d", load_cnt, l0); end
    endtask

    initial begin
        test_reset();
        test_mode_capture();
        test_edit_sequence();
        test_glitch();
        test_same_cycle();
        test_blink();
        test_out_of_range();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Pushbutton-driven time-set controller for the MM:SS seven-segment clock. It is the input side of the clock's BCD time interface: it reads the running time, lets the user edit each digit, and writes the edited time back through a one-cycle load strobe. It sits between the board's raw pushbuttons and the minutes/seconds counter. It also tells the display path which digit to blank while blinking the selected digit.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a button change (10 ms at 50 MHz).
- BLINK_DIV, 12500000: clk cycles per blink phase toggle.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- btn_mode_n  in  1  raw mode button, active-low, asynchronous to clk.
- btn_inc_n  in  1  raw increment button, active-low, asynchronous to clk.
- cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units  in  4 each  live BCD time from the counter.
- set_min_tens, set_min_units, set_sec_tens, set_sec_units  out  4 each  edited BCD time (shadow registers).
- load  out  1  one-cycle strobe; counter loads set_* on this cycle.
- editing  out  1  high in any EDIT state.
- digit_blank  out  4  per-digit blank request: [3]=min_tens, [2]=min_units, [1]=sec_tens, [0]=sec_units.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer. The press event is a one-cycle pulse on the debounced high-to-low transition. Release produces no event.
- FSM states: IDLE, EDIT_MT, EDIT_MU, EDIT_ST, EDIT_SU, COMMIT.
- IDLE + mode event: copy cur_* into the shadow registers, then go to EDIT_MT.
- EDIT_MT + mode goes to EDIT_MU. EDIT_MU + mode goes to EDIT_ST. EDIT_ST + mode goes to EDIT_SU. EDIT_SU + mode goes to COMMIT.
- COMMIT: load=1 for exactly that cycle, then unconditionally go to IDLE.
- EDIT_x + inc event increments only the selected shadow digit.
  - Tens digits wrap 5 to 0.
  - Units digits wrap 9 to 0.
  - A captured value above its range (tens >5, units >9) goes to 0 on the next increment.
- Inc events in IDLE or COMMIT are ignored.
- Mode and inc events in the same cycle: mode wins and inc is discarded.
- set_* always reflect the shadow registers, including in IDLE. They change only on capture or increment.
- Blink:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles.
  - The counter and blink_phase are cleared on every state change and on every increment, so the selected digit is visible immediately.
  - digit_blank bit i = (state edits digit i) AND blink_phase. All bits are 0 outside the EDIT states.
- Reset (any time, including mid-edit):
  - state=IDLE, shadow registers=0, load=0, editing=0, digit_blank=0.
  - Synchronizers and debounced levels are reset to 1 (released).
  - Counters are reset to 0.
  - No commit occurs.

## Timing
- Debounce: a counter increments while the synchronized level differs from the debounced level, and clears to 0 when they match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A clean press generates its event pulse exactly 2+DEBOUNCE_CYCLES rising edges after the raw falling edge.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- The FSM reacts on the edge after the event pulse: the state, shadow update, and editing change are visible one cycle after the pulse.
- load is high for exactly one cycle. It occurs one cycle after the EDIT_SU mode event.
- Outputs are registered, with no combinational path from inputs to outputs. Exception: digit_blank is decoded from registered state and blink_phase.

## Structure
- Shared package clock_pkg holds:
  - the FSM state enum;
  - BCD limit constants TENS_MAX=5 and UNITS_MAX=9;
  - digit index constants DIG_MT=3, DIG_MU=2, DIG_ST=1, DIG_SU=0, which the display block also uses.
- One sub-module, btn_debounce (synchronizer, debounce counter, press-pulse generator), parameterized by DEBOUNCE_CYCLES and instantiated twice.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BLINK_DIV=8.
1. Reset, then a clean mode press with cur=58:57: event 6 edges after the press, next cycle state=EDIT_MT. set_*=5,8,5,7. editing=1.
2. Sequence:
   - In EDIT_MT, 1 inc: min_tens goes 5 to 0.
   - Mode, then 2 inc in EDIT_MU: 8 to 9, then 9 to 0.
   - Mode, mode, then 3 inc in EDIT_SU: 7, 8, 9, 0.
   - Final mode: load high for exactly 1 cycle with set=00:50, then IDLE.
3. A 3-cycle low glitch on btn_inc_n in EDIT_ST produces no increment. A 4-cycle stable low produces exactly one increment.
4. Mode and inc event pulses in the same cycle in EDIT_MU: state goes to EDIT_ST and min_units is unchanged.
5. Blink in EDIT_ST: digit_blank=0000 for 8 cycles, 0010 for 8 cycles, and so on. An inc restarts the pattern at 0000.
6. rst_n low mid-EDIT_MU: the next sampled state is IDLE with set_*=0 and editing=0. No load pulse is ever observed.
